// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the fetch PC, issues requests
//                to instruction memory over a req/ack handshake, absorbs
//                memory wait states and ID back-pressure with a one-entry
//                skid buffer, and applies branch redirects from ID.
//                Optional macro IF_PERF_CNT_EN adds fetch/wait counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned INSN_BYTES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        flush_o,
    output logic        bubble_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] wait_cnt_o
`endif
);

    localparam logic [31:0] PC_INC = 32'(INSN_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        out_v, out_v_n;
    logic [31:0] out_pc, out_pc_n;
    logic [31:0] out_ins, out_ins_n;
    logic        sk_v, sk_v_n;
    logic [31:0] sk_pc, sk_pc_n;
    logic [31:0] sk_ins, sk_ins_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] addr_q, addr_n;
    logic        drop_q, drop_n;

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            out_v   <= 1'b0;
            out_pc  <= 32'h0;
            out_ins <= 32'h0;
            sk_v    <= 1'b0;
            sk_pc   <= 32'h0;
            sk_ins  <= 32'h0;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_n;
            out_v   <= out_v_n;
            out_pc  <= out_pc_n;
            out_ins <= out_ins_n;
            sk_v    <= sk_v_n;
            sk_pc   <= sk_pc_n;
            sk_ins  <= sk_ins_n;
            pc_q    <= pc_n;
            addr_q  <= addr_n;
            drop_q  <= drop_n;
        end
    end

    // Next-state logic: fetch sequencing, skid handling and branch redirect.
    always_comb begin
        state_n   = state;
        out_v_n   = out_v;
        out_pc_n  = out_pc;
        out_ins_n = out_ins;
        sk_v_n    = sk_v;
        sk_pc_n   = sk_pc;
        sk_ins_n  = sk_ins;
        pc_n      = pc_q;
        addr_n    = addr_q;
        drop_n    = drop_q;

        case (state)
            IDLE: begin
                state_n = REQ;
                addr_n  = branch_i ? branch_target_i : pc_q;
            end
            REQ: begin
                if (branch_i) begin
                    // An ack in the branch cycle retires the old request, so
                    // the target can be requested at once; otherwise the
                    // pending response must be swallowed first.
                    if (imem_ack_i) begin
                        addr_n = branch_target_i;
                        drop_n = 1'b0;
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (imem_ack_i) begin
                    if (drop_q) begin
                        drop_n = 1'b0;
                        addr_n = pc_q;
                        if (!stall_i) begin
                            out_v_n = 1'b0;
                        end
                    end else begin
                        pc_n   = pc_q + PC_INC;
                        addr_n = pc_q + PC_INC;
                        if (!out_v || !stall_i) begin
                            out_v_n   = 1'b1;
                            out_pc_n  = addr_q;
                            out_ins_n = imem_rdata_i;
                        end else begin
                            sk_v_n   = 1'b1;
                            sk_pc_n  = addr_q;
                            sk_ins_n = imem_rdata_i;
                            state_n  = FULL;
                        end
                    end
                end else if (!stall_i) begin
                    out_v_n = 1'b0;
                end
            end
            FULL: begin
                if (branch_i) begin
                    addr_n  = branch_target_i;
                    state_n = REQ;
                end else if (!stall_i) begin
                    out_v_n   = sk_v;
                    out_pc_n  = sk_pc;
                    out_ins_n = sk_ins;
                    sk_v_n    = 1'b0;
                    addr_n    = pc_q;
                    state_n   = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A redirect invalidates everything held and retargets the PC.
        if (branch_i) begin
            out_v_n = 1'b0;
            sk_v_n  = 1'b0;
            pc_n    = branch_target_i;
        end
    end

    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = addr_q;
    assign pc_o          = out_v ? out_pc  : 32'h0;
    assign instruction_o = out_v ? out_ins : 32'h0;
    assign flush_o       = branch_i;
    assign bubble_o      = ~out_v;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] wait_cnt;
    logic        fetch_hit;
    logic        wait_hit;

    assign fetch_hit = (state == REQ) & imem_ack_i & ~drop_q & ~branch_i;
    assign wait_hit  = (state == REQ) & ~imem_ack_i;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt <= 32'h0;
            wait_cnt  <= 32'h0;
        end else begin
            if (fetch_hit) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (wait_hit) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt;
    assign wait_cnt_o  = wait_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Scoreboard bench for if_fetch_unit. Directed stimulus pushes
//                expected (pc, instruction) pairs; a negedge monitor pops and
//                compares each instruction consumed by ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        flush_o;
    logic        bubble_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] wait_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .INSN_BYTES (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .pc_o            (pc_o),
        .instruction_o   (instruction_o),
        .flush_o         (flush_o),
        .bubble_o        (bubble_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o),
        .wait_cnt_o      (wait_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic stall,
                         input logic br, input logic [31:0] tgt);
        imem_ack_i      = ack;
        imem_rdata_i    = rdata;
        stall_i         = stall;
        branch_i        = br;
        branch_target_i = tgt;
        #1;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Reset, verify reset outputs, release, check the single IDLE cycle.
    task automatic do_reset;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick;
        tick;
        chk("rst_req", {31'h0, imem_req_o}, 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_ins", instruction_o, 32'h0);
        chk("rst_bubble", {31'h0, bubble_o}, 32'd1);
        chk("rst_flush", {31'h0, flush_o}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt_o, 32'h0);
        chk("rst_wait_cnt", wait_cnt_o, 32'h0);
`endif
        rst_i = 1'b1;
        #1;
        chk("idle_req", {31'h0, imem_req_o}, 32'd0);
        tick;
    endtask

    // Monitor: an instruction is consumed when presented, not stalled, not flushed.
    always @(negedge clk_i) begin
        if (rst_i && !bubble_o && !stall_i && !branch_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual pc=%h ins=%h required none", pc_o, instruction_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_pc", pc_o, e.pc);
                chk("out_ins", instruction_o, e.ins);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential fetch, then a 3-cycle wait state on 0x8.
        do_reset;
        chk("s1_req", {31'h0, imem_req_o}, 32'd1);
        chk("s1_addr0", imem_addr_o, 32'h0);
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); push(32'h0, 32'hA000_0000); tick;
        chk("s1_addr4", imem_addr_o, 32'h4);
        drive(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0); push(32'h4, 32'hA000_0004); tick;
        chk("s1_addr8", imem_addr_o, 32'h8);
        chk("s1_nobubble", {31'h0, bubble_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("s2_wait_req", {31'h0, imem_req_o}, 32'd1);
            chk("s2_wait_addr", imem_addr_o, 32'h8);
            tick;
            chk("s2_wait_bubble", {31'h0, bubble_o}, 32'd1);
        end
        drive(1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'h0); push(32'h8, 32'hA000_0008); tick;
        chk("s2_pc_after_ack", pc_o, 32'h8);
        chk("s2_addrC", imem_addr_o, 32'hC);
        drive(1'b1, 32'hA000_000C, 1'b0, 1'b0, 32'h0); push(32'hC, 32'hA000_000C); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        tick;

        // Stall with 0x4 presented while 0x8 is acked: skid then drain.
        do_reset;
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); push(32'h0, 32'hA000_0000); tick;
        drive(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0); push(32'h4, 32'hA000_0004); tick;
        drive(1'b1, 32'hA000_0008, 1'b1, 1'b0, 32'h0); push(32'h8, 32'hA000_0008);
        chk("s3_pc4", pc_o, 32'h4);
        tick;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("s3_full_req", {31'h0, imem_req_o}, 32'd0);
        chk("s3_hold_pc", pc_o, 32'h4);
        chk("s3_hold_ins", instruction_o, 32'hA000_0004);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s3_full_req2", {31'h0, imem_req_o}, 32'd0);
        chk("s3_hold_pc2", pc_o, 32'h4);
        tick;
        chk("s3_req_again", {31'h0, imem_req_o}, 32'd1);
        chk("s3_addrC", imem_addr_o, 32'hC);
        chk("s3_pc8", pc_o, 32'h8);
        tick;
        tick;

        // Branch to 0x100 while 0x10 is outstanding.
        do_reset;
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); push(32'h0, 32'hA000_0000); tick;
        drive(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0); push(32'h4, 32'hA000_0004); tick;
        drive(1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'h0); push(32'h8, 32'hA000_0008); tick;
        drive(1'b1, 32'hA000_000C, 1'b0, 1'b0, 32'h0); tick;
        chk("s4_addr10", imem_addr_o, 32'h10);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        chk("s4_flush", {31'h0, flush_o}, 32'd1);
        tick;
        drive(1'b1, 32'hA000_0010, 1'b0, 1'b0, 32'h0);
        chk("s4_flush_off", {31'h0, flush_o}, 32'd0);
        chk("s4_bubble", {31'h0, bubble_o}, 32'd1);
        chk("s4_addr_held", imem_addr_o, 32'h10);
        tick;
        chk("s4_drop_bubble", {31'h0, bubble_o}, 32'd1);
        chk("s4_addr100", imem_addr_o, 32'h100);
        drive(1'b1, 32'hA000_0100, 1'b0, 1'b0, 32'h0); push(32'h100, 32'hA000_0100); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        tick;

        // Branch + ack + stall together, then a branch to the top of memory.
        do_reset;
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); tick;
        drive(1'b1, 32'hA000_0004, 1'b1, 1'b1, 32'h200);
        chk("s5_flush", {31'h0, flush_o}, 32'd1);
        chk("s5_ins_pre", instruction_o, 32'hA000_0000);
        tick;
        drive(1'b1, 32'hA000_0200, 1'b0, 1'b0, 32'h0);
        chk("s5_bubble", {31'h0, bubble_o}, 32'd1);
        chk("s5_pc_zero", pc_o, 32'h0);
        chk("s5_req", {31'h0, imem_req_o}, 32'd1);
        chk("s5_addr200", imem_addr_o, 32'h200);
        push(32'h200, 32'hA000_0200);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s5_pc200", pc_o, 32'h200);
        tick;
        drive(1'b1, 32'hA000_0204, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("s5_bubble2", {31'h0, bubble_o}, 32'd1);
        tick;
        chk("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0); push(32'hFFFF_FFFC, 32'hFFFF_FFFC); tick;
        chk("wrap_addr_zero", imem_addr_o, 32'h0);
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); push(32'h0, 32'hA000_0000); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        tick;

        // Reset asserted during a wait state; stale ack after release is ignored.
        do_reset;
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); push(32'h0, 32'hA000_0000); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        chk("s6_wait_req", {31'h0, imem_req_o}, 32'd1);
        chk("s6_wait_addr", imem_addr_o, 32'h4);
        #1;
        rst_i = 1'b0;
        #1;
        chk("s6_async_req", {31'h0, imem_req_o}, 32'd0);
        chk("s6_async_pc", pc_o, 32'h0);
        chk("s6_async_bubble", {31'h0, bubble_o}, 32'd1);
`ifdef IF_PERF_CNT_EN
        chk("s6_fetch_cnt", fetch_cnt_o, 32'h0);
        chk("s6_wait_cnt", wait_cnt_o, 32'h0);
`endif
        tick;
        rst_i = 1'b1;
        drive(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0);
        chk("s6_idle_req", {31'h0, imem_req_o}, 32'd0);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("s6_req_reset_pc", {31'h0, imem_req_o}, 32'd1);
        chk("s6_addr_reset_pc", imem_addr_o, 32'h0);
        chk("s6_bubble_after", {31'h0, bubble_o}, 32'd1);
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0); push(32'h0, 32'hA000_0000); tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        tick;

        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
